// File: rtl/queue_pair_unpacker_pkg.sv
// Shared constants and helpers for the queue pair unpacker and its output stage.
// The queue produces read data one cycle after an accepted read.
package queue_pair_unpacker_pkg;

    localparam int unsigned InW       = 16;
    localparam int unsigned OutW      = 2 * InW;
    localparam int unsigned RdLatency = 1;

    // Words owned by the unpacker: one in flight from the queue plus one held as the low half.
    function automatic logic [1:0] occupancy(input logic pend, input logic have_lo);
        return {1'b0, pend} + {1'b0, have_lo};
    endfunction

endpackage

// File: rtl/queue_pair_unpacker_out_stage_reg.sv
// Valid/ready holding register; a load in the same cycle as an accept keeps valid high.
// Reusable by any stream stage that produces at most one word per cycle.
module queue_pair_unpacker_out_stage_reg
    import queue_pair_unpacker_pkg::*;
#(
    parameter int unsigned Width = OutW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    output logic             accept_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    always_comb begin
        accept_o = valid_q && ready_i;
        valid_d  = valid_q;
        data_d   = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end else if (accept_o) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/queue_pair_unpacker.sv
// Drains a 16-bit queue and packs consecutive word pairs into 32-bit valid/ready words.
// First-popped word lands in the low half; flush drops any partial pair.
module queue_pair_unpacker
    import queue_pair_unpacker_pkg::*;
#(
    parameter int unsigned IN_W  = InW,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              q_empty,
    input  logic [IN_W-1:0]   q_dout,
    output logic              q_read,
    input  logic              flush,
    output logic [2*IN_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  pair_count
);

    logic [RdLatency-1:0] pend_q, pend_d;
    logic                 have_lo_q, have_lo_d;
    logic                 discard_q, discard_d;
    logic [IN_W-1:0]      lo_q, lo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           n;
    logic                 room;
    logic                 arrive;
    logic                 load;
    logic                 accept;

    always_comb begin
        n         = occupancy(pend_q, have_lo_q);
        room      = !out_valid || out_ready;
        q_read    = !q_empty && !flush && ((n == 2'd0) || ((n == 2'd1) && room));
        pend_d    = q_read;
        // A flush drops the word on q_dout this cycle together with any held low half.
        arrive    = pend_q && !discard_q && !flush;
        discard_d = flush && pend_q;
        have_lo_d = have_lo_q;
        lo_d      = lo_q;
        load      = 1'b0;
        if (flush) begin
            have_lo_d = 1'b0;
        end else if (arrive) begin
            if (!have_lo_q) begin
                lo_d      = q_dout;
                have_lo_d = 1'b1;
            end else begin
                load      = 1'b1;
                have_lo_d = 1'b0;
            end
        end
        cnt_d = cnt_q + CNT_W'(accept);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q    <= '0;
            have_lo_q <= 1'b0;
            discard_q <= 1'b0;
            lo_q      <= '0;
            cnt_q     <= '0;
        end else begin
            pend_q    <= pend_d;
            have_lo_q <= have_lo_d;
            discard_q <= discard_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
        end
    end

    queue_pair_unpacker_out_stage_reg #(
        .Width (2 * IN_W)
    ) u_out_stage (
        .clk_i       (clk),
        .rst_ni      (reset),
        .load_i      (load),
        .load_data_i ({q_dout, lo_q}),
        .ready_i     (out_ready),
        .valid_o     (out_valid),
        .data_o      (out_data),
        .accept_o    (accept)
    );

    assign pair_count = cnt_q;

endmodule

// File: tb/tb_queue_pair_unpacker.sv
// Directed bench for queue_pair_unpacker with a one-cycle-latency queue model
// and monitors for accepted words, output stability and reads while empty.
module tb_queue_pair_unpacker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        q_empty;
    logic [15:0] q_dout = 16'h0;
    logic        q_read;
    logic        flush = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] pair_count;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem [0:255];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;

    logic [31:0] out_log [0:63];
    int          out_n = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'h0;

    queue_pair_unpacker dut (
        .clk        (clk),
        .reset      (reset),
        .q_empty    (q_empty),
        .q_dout     (q_dout),
        .q_read     (q_read),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pair_count (pair_count)
    );

    always #5 clk = ~clk;

    assign q_empty = (wr_ptr == rd_ptr);

    // Queue model: read accepted at an edge presents its data after that edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= wr_ptr;
        end else if (q_read && !q_empty) begin
            q_dout <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 8'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (q_empty) check("no_read_when_empty", {31'd0, q_read}, 32'd0);
            if (prev_stall) begin
                check("stall_valid_held", {31'd0, out_valid}, 32'd1);
                check("stall_data_held", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                out_log[out_n] = out_data;
                out_n++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic wait_outs(input int target, input string tag);
        int cyc = 0;
        while (out_n < target && cyc < 200) begin
            tick();
            cyc++;
        end
        check(tag, out_n, target);
    endtask

    initial begin
        #2;
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_data", out_data, 32'h0);
        check("reset_count", {16'd0, pair_count}, 32'd0);
        check("reset_read", {31'd0, q_read}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Single pair with consumer always ready.
        out_ready = 1'b1;
        push(16'h1111);
        push(16'h2222);
        wait_outs(1, "t1_outs");
        tick();
        tick();
        check("t1_word", out_log[0], 32'h2222_1111);
        check("t1_valid_drops", {31'd0, out_valid}, 32'd0);
        check("t1_count", {16'd0, pair_count}, 32'd1);

        // Six words stream into three pairs in order.
        for (int i = 1; i <= 6; i++) push(16'(i));
        wait_outs(4, "t2_outs");
        tick();
        tick();
        check("t2_word0", out_log[1], 32'h0002_0001);
        check("t2_word1", out_log[2], 32'h0004_0003);
        check("t2_word2", out_log[3], 32'h0006_0005);
        check("t2_count", {16'd0, pair_count}, 32'd4);

        // Backpressure: one completed pair held, only one extra word fetched.
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(16'(i));
        repeat (10) tick();
        check("t3_held_data", out_data, 32'h0002_0001);
        check("t3_held_valid", {31'd0, out_valid}, 32'd1);
        check("t3_queue_left", {24'd0, wr_ptr - rd_ptr}, 32'd1);
        check("t3_count_frozen", {16'd0, pair_count}, 32'd4);
        out_ready = 1'b1;
        wait_outs(6, "t3_outs");
        tick();
        tick();
        check("t3_word0", out_log[4], 32'h0002_0001);
        check("t3_word1", out_log[5], 32'h0004_0003);
        check("t3_count", {16'd0, pair_count}, 32'd6);

        // Flush while a low half is held.
        push(16'hAAAA);
        repeat (4) tick();
        check("t4_no_early_out", out_n, 6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        push(16'hBBBB);
        push(16'hCCCC);
        wait_outs(7, "t4_outs");
        tick();
        tick();
        check("t4_word", out_log[6], 32'hCCCC_BBBB);
        check("t4_count", {16'd0, pair_count}, 32'd7);

        // Flush while a read is in flight drops the arriving word.
        push(16'h5555);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        push(16'h6666);
        push(16'h7777);
        wait_outs(8, "t5_outs");
        tick();
        tick();
        check("t5_word", out_log[7], 32'h7777_6666);
        check("t5_count", {16'd0, pair_count}, 32'd8);

        // Asynchronous reset with a word pending on the output.
        out_ready = 1'b0;
        push(16'h1234);
        push(16'h5678);
        for (int c = 0; c < 20 && !out_valid; c++) tick();
        check("t6_valid_before", {31'd0, out_valid}, 32'd1);
        check("t6_data_before", out_data, 32'h5678_1234);
        #2;
        reset = 1'b0;
        #1;
        check("t6_valid_async", {31'd0, out_valid}, 32'd0);
        check("t6_count_async", {16'd0, pair_count}, 32'd0);
        check("t6_data_async", out_data, 32'h0);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        push(16'h9ABC);
        push(16'hDEF0);
        wait_outs(9, "t6_outs");
        tick();
        tick();
        check("t6_word", out_log[8], 32'hDEF0_9ABC);
        check("t6_count", {16'd0, pair_count}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
